// File: rtl/i2c_target_regfile_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK,
    RDATA, RDATA_ACK, IGNORE, WAIT
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic addr_match(input logic [6:0] rx,
                                      input logic [6:0] target,
                                      input logic [6:0] mask);
    return ((rx ^ target) & mask) == 7'd0;
  endfunction

endpackage

// File: rtl/i2c_target_regfile_bus_sync.sv
// SCL/SDA synchronisers and single-cycle SCL edge / START / STOP pulses.
module i2c_bus_sync
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
  logic scl_s, scl_q, sda_q;

  // Idle bus is high, so everything resets to 1 to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s    = scl_ff[SYNC_STAGES-1];
  assign sda_s    = sda_ff[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target with auto-incrementing register file and host port.
// Optional SCL stretching after each ACK when I2C_TARGET_STRETCH_EN is defined.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h44,
  parameter logic [6:0]  ADDR_MASK   = 7'h7F,
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  localparam int unsigned PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          scl_o,
  input  logic          stretch_req,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          i2c_wr_stb,
  output logic [PW-1:0] i2c_wr_idx,
  output logic          busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t        state, state_n;
  logic [3:0]    bit_cnt, cnt_n;
  logic [7:0]    shift, shift_n, wr_data, wdat_n;
  logic [PW-1:0] ptr, ptr_n, ptr_inc, idx_n;
  logic          sda_n, busy_n, stb_n, ack_fall;
  logic [7:0]    regs [NUM_REGS];

  assign ptr_inc    = ptr + 1'b1;
  assign host_rdata = regs[host_addr];

  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    shift_n  = shift;
    ptr_n    = ptr;
    sda_n    = sda_o;
    busy_n   = busy;
    stb_n    = 1'b0;
    idx_n    = i2c_wr_idx;
    wdat_n   = wr_data;
    ack_fall = 1'b0;
    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      sda_n   = 1'b1;
      cnt_n   = '0;
    end else if (start) begin
      state_n = ADDR;
      busy_n  = 1'b0;
      sda_n   = 1'b1;
      cnt_n   = '0;
    end else if (scl_rise) begin
      case (state)
        ADDR, REG, WDATA: if (bit_cnt != 4'd8) begin
          shift_n = {shift[6:0], sda_s};
          cnt_n   = bit_cnt + 4'd1;
        end
        RDATA:     if (bit_cnt != 4'd8) cnt_n = bit_cnt + 4'd1;
        RDATA_ACK: shift_n[0] = sda_s;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: if (bit_cnt == 4'd8) begin
          cnt_n = '0;
          if (addr_match(shift[7:1], TARGET_ADDR, ADDR_MASK)) begin
            state_n = ADDR_ACK;
            sda_n   = I2C_ACK;
            busy_n  = 1'b1;
          end else begin
            state_n = IGNORE;
          end
        end
        ADDR_ACK: begin
          ack_fall = 1'b1;
          cnt_n    = '0;
          if (shift[0]) begin
            state_n = RDATA;
            shift_n = regs[ptr];
            sda_n   = regs[ptr][7];
          end else begin
            state_n = REG;
            sda_n   = 1'b1;
          end
        end
        REG: if (bit_cnt == 4'd8) begin
          state_n = REG_ACK;
          ptr_n   = shift[PW-1:0];
          sda_n   = I2C_ACK;
          cnt_n   = '0;
        end
        REG_ACK, WDATA_ACK: begin
          ack_fall = 1'b1;
          state_n  = WDATA;
          sda_n    = 1'b1;
        end
        WDATA: if (bit_cnt == 4'd8) begin
          state_n = WDATA_ACK;
          sda_n   = I2C_ACK;
          stb_n   = 1'b1;
          idx_n   = ptr;
          wdat_n  = shift;
          ptr_n   = ptr_inc;
          cnt_n   = '0;
        end
        // Shift register holds the byte latched at byte start; bit 6 is the next bit out.
        RDATA: if (bit_cnt == 4'd8) begin
          state_n = RDATA_ACK;
          sda_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          sda_n   = shift[6];
          shift_n = {shift[6:0], 1'b0};
        end
        RDATA_ACK: begin
          ack_fall = 1'b1;
          ptr_n    = ptr_inc;
          if (shift[0] == I2C_ACK) begin
            state_n = RDATA;
            shift_n = regs[ptr_inc];
            sda_n   = regs[ptr_inc][7];
          end else begin
            state_n = WAIT;
            sda_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ptr        <= '0;
      sda_o      <= 1'b1;
      busy       <= 1'b0;
      i2c_wr_stb <= 1'b0;
      i2c_wr_idx <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      shift      <= shift_n;
      ptr        <= ptr_n;
      sda_o      <= sda_n;
      busy       <= busy_n;
      i2c_wr_stb <= stb_n;
      i2c_wr_idx <= idx_n;
      wr_data    <= wdat_n;
    end
  end

  // Bus write commits while the strobe is high; the later host assignment wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (i2c_wr_stb) regs[i2c_wr_idx] <= wr_data;
      if (host_we)    regs[host_addr]  <= host_wdata;
    end
  end

`ifdef I2C_TARGET_STRETCH_EN
  logic stretch, stretch_n;

  always_comb begin
    stretch_n = stretch;
    if (stop || start)              stretch_n = 1'b0;
    else if (ack_fall && stretch_req) stretch_n = 1'b1;
    else if (!stretch_req)          stretch_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stretch <= 1'b0;
    else     stretch <= stretch_n;
  end

  assign scl_o = ~stretch;
`else
  logic unused_stretch;
  assign unused_stretch = stretch_req ^ ack_fall;
  assign scl_o = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Randomised bus-master bench with a register-file reference model and scoreboard queues.
module tb_i2c_target_regfile;

  localparam int unsigned NUM_REGS = 16;
  localparam int Q = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic stretch_req = 1'b0, host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;

  logic sda_o, scl_o, i2c_wr_stb, busy;
  logic [7:0] host_rdata;
  logic [3:0] i2c_wr_idx;
  logic m_sda_o, m_scl_o, m_stb, m_busy;
  logic [7:0] m_rdata;
  logic [3:0] m_idx;
  logic scl_bus, sda_bus;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_target_regfile #(.TARGET_ADDR(7'h44), .ADDR_MASK(7'h7F), .NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_bus), .sda_i(sda_bus), .sda_o(sda_o), .scl_o(scl_o),
    .stretch_req(stretch_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .i2c_wr_stb(i2c_wr_stb), .i2c_wr_idx(i2c_wr_idx), .busy(busy));

  // Second target with a relaxed mask listens to the same bus but does not drive it.
  i2c_target_regfile #(.TARGET_ADDR(7'h44), .ADDR_MASK(7'h7E), .NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut_m (
    .clk(clk), .rst(rst), .scl_i(scl_bus), .sda_i(sda_bus), .sda_o(m_sda_o), .scl_o(m_scl_o),
    .stretch_req(stretch_req), .host_we(1'b0), .host_addr(4'd0), .host_wdata(8'd0),
    .host_rdata(m_rdata), .i2c_wr_stb(m_stb), .i2c_wr_idx(m_idx), .busy(m_busy));

  logic [7:0] mregs [NUM_REGS];
  int unsigned mptr;
  int unsigned exp_stb_q[$];
  logic [7:0] exp_rd_q[$], got_rd_q[$], dq[$];
  int n_checks = 0, n_fail = 0;
  logic m_sda_last;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_rel();
    scl_m = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (scl_bus) break;
      @(negedge clk);
    end
    if (!scl_bus) fail_now("scl_release_timeout");
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    wclk(Q);
    scl_rel();
    wclk(Q);
    s = sda_bus;
    m_sda_last = m_sda_o;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wclk(Q);
    scl_rel();
    wclk(Q);
    sda_m = 1'b0;
    wclk(Q);
    scl_m = 1'b0;
    wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wclk(Q);
    scl_rel();
    wclk(Q);
    sda_m = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic byte_out(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic byte_in(input logic ackbit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(ackbit, s);
  endtask

  // Write transaction: pointer byte then every byte queued in dq.
  task automatic wr_txn(input logic [7:0] p, input bit do_stop, input bit st);
    logic a;
    int cnt;
    if (st) stretch_req = 1'b1;
    i2c_start();
    byte_out(8'h88, a);
    chk("addr_ack", a, 0);
    chk("busy_after_match", busy, 1);
    if (st) begin
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!scl_o) cnt++;
      end
`ifdef I2C_TARGET_STRETCH_EN
      chk("stretch_hold_clks", cnt, 40);
`else
      chk("scl_never_held", cnt, 0);
`endif
      stretch_req = 1'b0;
      wclk(2);
      chk("stretch_released", scl_o, 1);
    end
    byte_out(p, a);
    chk("ptr_ack", a, 0);
    mptr = p % NUM_REGS;
    foreach (dq[k]) begin
      exp_stb_q.push_back(mptr);
      mregs[mptr] = dq[k];
      mptr = (mptr + 1) % NUM_REGS;
      byte_out(dq[k], a);
      chk("data_ack", a, 0);
    end
    if (do_stop) begin
      i2c_stop();
      chk("busy_after_stop", busy, 0);
    end
  endtask

  task automatic rd_txn(input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    byte_out(8'h89, a);
    chk("rd_addr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(mregs[mptr]);
      mptr = (mptr + 1) % NUM_REGS;
      byte_in((i == n - 1) ? 1'b1 : 1'b0, d);
      got_rd_q.push_back(d);
    end
    wclk(Q);
    chk("sda_released_after_nack", sda_o, 1);
    i2c_stop();
  endtask

  task automatic readback(input string nm);
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = i[3:0];
      wclk(1);
      chk(nm, host_rdata, mregs[i]);
    end
  endtask

  initial begin : stb_monitor
    forever begin
      @(negedge clk);
      if (i2c_wr_stb) begin
        if (exp_stb_q.size() == 0) fail_now("unexpected_wr_stb");
        else chk("wr_stb_idx", i2c_wr_idx, exp_stb_q.pop_front());
      end
    end
  end

  initial begin : rd_monitor
    logic [7:0] g;
    forever begin
      @(negedge clk);
      if (got_rd_q.size() != 0) begin
        g = got_rd_q.pop_front();
        if (exp_rd_q.size() == 0) fail_now("unexpected_read_byte");
        else chk("read_byte", g, exp_rd_q.pop_front());
      end
    end
  end

  initial begin : main
    logic a, collided;
    logic [7:0] x, y, a8;
    int n;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    wclk(3);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_stb", i2c_wr_stb, 0);
    chk("rst_idx", i2c_wr_idx, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wclk(4);
    readback("rst_regs");

    dq = '{8'hA5, 8'h5A};
    wr_txn(8'h03, 1'b1, 1'b0);
    dq = '{8'h11, 8'h22};
    wr_txn(8'h0F, 1'b1, 1'b0);
    dq = {};
    wr_txn(8'h02, 1'b0, 1'b0);
    rd_txn(3);

    i2c_start();
    byte_out(8'h8A, a);
    chk("mask7f_nack", a, 1);
    chk("mask7e_ack", m_sda_last, 0);
    chk("mask7f_busy", busy, 0);
    chk("mask7e_busy", m_busy, 1);
    byte_out(8'h07, a);
    chk("ignore_nack", a, 1);
    i2c_stop();

    x = 8'($urandom);
    y = x ^ 8'hFF;
    collided = 1'b0;
    fork
      begin
        dq = '{x};
        wr_txn(8'h05, 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 6000 && !collided; i++) begin
          @(negedge clk);
          if (i2c_wr_stb && i2c_wr_idx == 4'd5) begin
            host_addr = 4'd5;
            host_wdata = y;
            host_we = 1'b1;
            @(negedge clk);
            host_we = 1'b0;
            collided = 1'b1;
          end
        end
      end
    join
    mregs[5] = y;
    chk("collision_seen", collided, 1);

    dq = '{8'($urandom)};
    wr_txn(8'($urandom), 1'b1, 1'b1);

    repeat (10) begin
      if ($urandom_range(0, 1) == 1) begin
        dq = {};
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
        wr_txn(8'($urandom), 1'b1, 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          dq = {};
          wr_txn(8'($urandom), 1'b0, 1'b0);
        end
        rd_txn($urandom_range(1, 3));
      end
    end
    readback("final_regs");

    i2c_start();
    a8 = 8'h88;
    for (int i = 7; i >= 0; i--) clk_bit(a8[i], a);
    sda_m = 1'b1;
    wclk(Q);
    scl_rel();
    wclk(Q);
    chk("ack_before_rst", sda_o, 0);
    rst = 1'b1;
    #1;
    chk("sda_after_rst", sda_o, 1);
    chk("busy_after_rst", busy, 0);
    wclk(2);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    scl_m = 1'b0;
    wclk(Q);
    i2c_stop();
    readback("post_rst_regs");
    rd_txn(2);

    for (int i = 0; i < 200 && (got_rd_q.size() != 0 || exp_stb_q.size() != 0); i++) wclk(1);
    chk("stb_queue_drained", exp_stb_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
